// File: rtl/id_operand_stage.sv
// ID operand stage: register-file addressing, WB/MEM bypass, load-use bubble
// insertion and the ID/EX pipeline register with a saturating stall counter.
module id_operand_stage #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic [31:0]       id_instr_i,
  input  logic [31:0]       id_pc4_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic [4:0]        id_dest_i,
  output logic [4:0]        rr1_o,
  output logic [4:0]        rr2_o,
  input  logic [31:0]       rd1_i,
  input  logic [31:0]       rd2_i,
  input  logic              mem_wen_i,
  input  logic [4:0]        mem_wr_i,
  input  logic [31:0]       mem_data_i,
  input  logic              wb_wen_i,
  input  logic [4:0]        wb_wr_i,
  input  logic [31:0]       wb_data_i,
  input  logic              flush_i,
  input  logic              ex_hold_i,
  output logic              id_stall_o,
  output logic              ex_valid_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [4:0]        ex_rs_o,
  output logic [4:0]        ex_rt_o,
  output logic [4:0]        ex_dest_o,
  output logic [31:0]       ex_op_a_o,
  output logic [31:0]       ex_op_b_o,
  output logic [31:0]       ex_imm_o,
  output logic [31:0]       ex_pc4_o,
  output logic              ex_fwd_a_o,
  output logic              ex_fwd_b_o,
  output logic [CNT_W-1:0]  stall_count_o
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        dest;
    logic [31:0]       op_a;
    logic [31:0]       op_b;
    logic [31:0]       imm;
    logic [31:0]       pc4;
    logic              fwd_a;
    logic              fwd_b;
  } idex_t;

  idex_t            ex_d, ex_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  logic [4:0]  rs, rt;
  logic [31:0] op_a, op_b;
  logic        fwd_a, fwd_b, load_use;
  logic        unused_opcode;

  assign rs            = id_instr_i[25:21];
  assign rt            = id_instr_i[20:16];
  assign rr1_o         = rs;
  assign rr2_o         = rt;
  assign unused_opcode = ^id_instr_i[31:26];

  // MEM result is newer than the WB write, so it wins when both match
  assign op_a = (rs == 5'd0)                     ? 32'd0      :
                (mem_wen_i && (mem_wr_i == rs))  ? mem_data_i :
                (wb_wen_i  && (wb_wr_i  == rs))  ? wb_data_i  : rd1_i;
  assign op_b = (rt == 5'd0)                     ? 32'd0      :
                (mem_wen_i && (mem_wr_i == rt))  ? mem_data_i :
                (wb_wen_i  && (wb_wr_i  == rt))  ? wb_data_i  : rd2_i;

  assign fwd_a = ex_q.valid && ex_q.reg_write && !ex_q.mem_read &&
                 (ex_q.dest != 5'd0) && (ex_q.dest == rs) && id_use_rs_i;
  assign fwd_b = ex_q.valid && ex_q.reg_write && !ex_q.mem_read &&
                 (ex_q.dest != 5'd0) && (ex_q.dest == rt) && id_use_rt_i;

  assign load_use = id_valid_i && ex_q.valid && ex_q.mem_read && (ex_q.dest != 5'd0) &&
                    ((id_use_rs_i && (ex_q.dest == rs)) || (id_use_rt_i && (ex_q.dest == rt)));

  assign id_stall_o = !flush_i && (ex_hold_i || load_use);

  // Next-state for ID/EX: flush > hold > load-use bubble > capture
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (ex_hold_i) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ex_d.valid     = id_valid_i;
      ex_d.reg_write = id_valid_i && id_reg_write_i;
      ex_d.mem_read  = id_valid_i && id_mem_read_i;
      ex_d.ctrl      = id_ctrl_i;
      ex_d.rs        = rs;
      ex_d.rt        = rt;
      ex_d.dest      = id_dest_i;
      ex_d.op_a      = op_a;
      ex_d.op_b      = op_b;
      ex_d.imm       = {{16{id_instr_i[15]}}, id_instr_i[15:0]};
      ex_d.pc4       = id_pc4_i;
      ex_d.fwd_a     = fwd_a;
      ex_d.fwd_b     = fwd_b;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid_o     = ex_q.valid;
  assign ex_reg_write_o = ex_q.reg_write;
  assign ex_mem_read_o  = ex_q.mem_read;
  assign ex_ctrl_o      = ex_q.ctrl;
  assign ex_rs_o        = ex_q.rs;
  assign ex_rt_o        = ex_q.rt;
  assign ex_dest_o      = ex_q.dest;
  assign ex_op_a_o      = ex_q.op_a;
  assign ex_op_b_o      = ex_q.op_b;
  assign ex_imm_o       = ex_q.imm;
  assign ex_pc4_o       = ex_q.pc4;
  assign ex_fwd_a_o     = ex_q.fwd_a;
  assign ex_fwd_b_o     = ex_q.fwd_b;
  assign stall_count_o  = cnt_q;

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Sits directly downstream of the register file, between IF/ID and EX.
- Drives the register-file read addresses from the decoded instruction.
- Bypasses same-cycle WB writes and MEM-stage results into the operands.
- Detects load-use hazards and inserts bubbles; registers everything into the ID/EX pipeline register with stall/flush control.
- Also keeps a saturating stall counter for performance monitoring.

Parameters:
- CTRL_W, 16, width of the opaque decoded-control bundle carried to EX.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; rst=0 clears all state immediately.
- id_valid  in  1  IF/ID holds a real instruction.
- id_instr  in  32  instruction word; rs=[25:21], rt=[20:16], imm=[15:0].
- id_pc4  in  32  PC+4 of the ID instruction.
- id_ctrl  in  CTRL_W  decoded control bundle.
- id_use_rs, id_use_rt  in  1 each  instruction actually reads rs / rt.
- id_reg_write  in  1  instruction writes a register.
- id_mem_read  in  1  instruction is a load.
- id_dest  in  5  destination register selected by the decoder.
- rr1, rr2  out  5 each  register-file read addresses (rs, rt); combinational.
- rd1, rd2  in  32 each  register-file read data; combinational.
- mem_wen  in  1  MEM-stage instruction writes a register.
- mem_wr  in  5  MEM-stage destination register.
- mem_data  in  32  MEM-stage final write-back value, including load data.
- wb_wen  in  1  WB-stage register-file write enable.
- wb_wr  in  5  WB-stage destination register.
- wb_data  in  32  WB-stage write data.
- flush  in  1  branch/jump resolved in EX; kill the ID instruction.
- ex_hold  in  1  EX or later stage cannot accept.
- id_stall  out  1  hold IF/ID and PC; combinational.
- ex_valid, ex_reg_write, ex_mem_read  out  1 each  registered.
- ex_ctrl  out  CTRL_W  registered control bundle.
- ex_rs, ex_rt, ex_dest  out  5 each  registered register numbers.
- ex_op_a, ex_op_b  out  32 each  registered operand values.
- ex_imm  out  32  registered sign-extended immediate.
- ex_pc4  out  32  registered PC+4.
- ex_fwd_a, ex_fwd_b  out  1 each  EX must take the EX/MEM ALU result for operand a / b.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (rst=0, asynchronous): every ex_* output and stall_count become 0. Outputs stay 0 until the first rising edge with rst=1.
- Addresses: rr1=id_instr[25:21] and rr2=id_instr[20:16] at all times.
- Operand select for a (rs); operand b (rt) is identical using rd2:
  - rs==0 gives 0;
  - else mem_wen && mem_wr==rs gives mem_data;
  - else wb_wen && wb_wr==rs gives wb_data (this covers the register-file write landing on this same edge);
  - else rd1.
  - MEM beats WB when both match.
- ex_fwd_a is set at capture when all hold: current ex_valid, ex_reg_write, !ex_mem_read, ex_dest!=0, ex_dest==rs, id_use_rs. ex_fwd_b uses rt and id_use_rt.
- The captured ex_op value is still the bypassed value; EX overrides it when ex_fwd_* is set.
- load_use = id_valid && ex_valid && ex_mem_read && ex_dest!=0 && ((id_use_rs && ex_dest==rs) || (id_use_rt && ex_dest==rt)).
- Per-edge priority, highest first:
  1. flush: ID/EX becomes a bubble (ex_valid, ex_reg_write, ex_mem_read, ex_fwd_*, ex_ctrl all 0; other fields don't-care but zeroed). id_stall=0.
  2. ex_hold: all ID/EX registers hold. id_stall=1.
  3. load_use: ID/EX becomes a bubble. id_stall=1. stall_count increments, saturating at all-ones.
  4. Otherwise: capture the ID instruction. ex_valid=id_valid. When id_valid=0, ex_reg_write and ex_mem_read are forced to 0.
- Load-use latency: exactly 1 bubble; on the next cycle the load is in MEM and is bypassed via mem_data.
- id_stall = !flush && (ex_hold || load_use).
- ex_imm = {{16{id_instr[15]}}, id_instr[15:0]}.
- Register 0 never forwards, never causes a stall and never sets ex_fwd_*.

Test Plan:
- Reset: drive rst=0 mid-run with ex_valid=1 -> all ex_* and stall_count read 0 before the next clk edge.
- WB bypass: wb_wen=1, wb_wr=5, wb_data=0xDEADBEEF, rd1=0x11, id_instr rs=5 -> ex_op_a=0xDEADBEEF after the edge. With wb_wr=0 instead -> ex_op_a=0x11.
- MEM/WB priority: mem_wr=wb_wr=7, mem_data=0xA, wb_data=0xB, rt=7 -> ex_op_b=0xA.
- Load-use: `lw $3` captured, then `add` reading $3 in ID ->
  - id_stall=1 for 1 cycle, bubble (ex_valid=0), stall_count=1;
  - next edge captures `add` with ex_op from mem_data and ex_fwd_a=0.
  - Non-load producer instead -> no stall, ex_fwd_a=1.
- Flush vs hold: flush=1 and ex_hold=1 together -> ex_valid=0, id_stall=0. ex_hold alone for 3 cycles -> all ex_* unchanged, id_stall=1.
- Saturation: force 2^CNT_W+2 load-use stalls -> stall_count stays at all-ones.
